// File: rtl/spi_transaction_arbiter.sv
// spi_transaction_arbiter
//
// Shares one SPI master between NREQ requesters. Each granted transaction is
// one chip-select window: CS setup delay, 2..4 bytes sent, one readback byte
// (or an rx timeout), CS hold delay, then a one-cycle completion pulse.
// Arbitration is round-robin; the winner's request fields are latched at grant
// and its req lines are ignored until the transaction completes.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   req[NREQ]            per-requester transaction request (level)
//   req_chip[3*NREQ]     chip index per requester
//   req_nbytes[3*NREQ]   bytes to send per requester (clamped to 2..4)
//   req_data[32*NREQ]    bytes to send per requester, [31:24] first
//   gnt[NREQ]            one-hot grant for the whole transaction
//   done[NREQ]           one-cycle completion pulse to the winner
//   err                  rx timeout flag, valid with done
//   rdata[8]             last captured readback byte
//   busy                 transaction in progress
//   spitx/spitxdv        byte + strobe to the SPI master
//   spitxready           SPI master can accept a byte
//   spirx/spirxdv        received byte + strobe from the SPI master
//   spics[8]             active-low chip selects
//   spimisossel[3]       MISO mux select

module spi_transaction_arbiter #(
    parameter int NREQ       = 2,
    parameter int CS_SETUP   = 6,
    parameter int CS_HOLD    = 16,
    parameter int RX_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_chip,
    input  logic [3*NREQ-1:0]    req_nbytes,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic [7:0]           spitx,
    output logic                 spitxdv,
    input  logic                 spitxready,
    input  logic [7:0]           spirx,
    input  logic                 spirxdv,
    output logic [7:0]           spics,
    output logic [2:0]           spimisossel
);

    localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CMAX   = (CMAX_A > RX_TIMEOUT) ? CMAX_A : RX_TIMEOUT;
    localparam int CW     = $clog2(CMAX + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        GAP,
        WAIT_RX,
        HOLD,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   ptr;        // last winner; search starts one past it
    logic [PW-1:0]   win;        // requester owning the current transaction
    logic [2:0]      chip_q;
    logic [2:0]      left;       // bytes still to send, including current
    logic [31:0]     sr;         // outgoing bytes, current byte in [31:24]
    logic [CW-1:0]   cnt;        // shared by setup, rx timeout and hold
    logic            err_q;
    logic [7:0]      rdata_q;

    logic            any_req;
    logic [PW-1:0]   pick;
    logic [2:0]      nb_raw;
    logic [2:0]      nb_clamp;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at ptr+1, ptr+2, ... (mod NREQ).
    // ------------------------------------------------------------------
    always_comb begin
        any_req = 1'b0;
        pick    = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any_req && req[(int'(ptr) + i) % NREQ]) begin
                any_req = 1'b1;
                pick    = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // Byte count outside 2..4 is clamped to the nearest legal value.
    always_comb begin
        nb_raw = req_nbytes[3*pick +: 3];
        if (nb_raw < 3'd2)
            nb_clamp = 3'd2;
        else if (nb_raw > 3'd4)
            nb_clamp = 3'd4;
        else
            nb_clamp = nb_raw;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)                  state_nxt = SETUP;
            SETUP:   if (cnt == CW'(CS_SETUP))     state_nxt = SEND;
            SEND:    if (spitxready)               state_nxt = GAP;
            // left still counts the byte just sent
            GAP:     state_nxt = (left > 3'd1) ? SEND : WAIT_RX;
            WAIT_RX: if (spirxdv || cnt == CW'(RX_TIMEOUT))
                                                   state_nxt = HOLD;
            HOLD:    if (cnt == CW'(CS_HOLD))      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched request, byte shifter, counter, readback
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr     <= PW'(NREQ - 1);
            win     <= '0;
            chip_q  <= '0;
            left    <= '0;
            sr      <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win    <= pick;
                        ptr    <= pick;
                        chip_q <= req_chip[3*pick +: 3];
                        left   <= nb_clamp;
                        sr     <= req_data[32*pick +: 32];
                        cnt    <= '0;
                        err_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    cnt <= cnt + 1'b1;
                end
                GAP: begin
                    sr   <= {sr[23:0], 8'h00};
                    left <= left - 3'd1;
                    cnt  <= '0;
                end
                WAIT_RX: begin
                    // rx strobe wins over a timeout landing on the same cycle
                    if (spirxdv) begin
                        rdata_q <= spirx;
                        cnt     <= '0;
                    end else if (cnt == CW'(RX_TIMEOUT)) begin
                        err_q <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from state so a reset drops everything at once
    // ------------------------------------------------------------------
    always_comb begin
        spics   = 8'hff;
        gnt     = '0;
        busy    = 1'b0;
        done    = '0;
        err     = 1'b0;
        spitxdv = 1'b0;
        spitx   = 8'h00;
        if (state inside {SETUP, SEND, GAP, WAIT_RX, HOLD}) begin
            spics    = ~(8'h01 << chip_q);
            gnt[win] = 1'b1;
            busy     = 1'b1;
        end
        case (state)
            SEND: begin
                spitx   = sr[31:24];
                spitxdv = spitxready;
            end
            DONE: begin
                done[win] = 1'b1;
                err       = err_q;
            end
            default: ;
        endcase
    end

    assign spimisossel = chip_q;
    assign rdata       = rdata_q;

endmodule
